// File: rtl/tx_gen_pkg.sv
// Shared types and constants for the command-driven TX stream generator:
// payload modes, FSM states, command/abort/terminator bytes and the LFSR step.
package tx_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2
  } mode_e;

  typedef enum logic {
    ST_CMD  = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int         CMD_BYTES  = 6;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
  localparam logic [7:0] TERM_BYTE  = 8'hEE;

  function automatic logic [7:0] lfsr_step(input logic [7:0] b);
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
  endfunction

endpackage

// File: rtl/tx_gen_pattern.sv
// Combinational payload generator: one beat of 2^TX_EW bytes from the current
// seed/LFSR state, plus the state to use for the following beat.
module tx_gen_pattern
  import tx_gen_pkg::*;
#(
  parameter int TX_EW = 2
) (
  input  mode_e                     mode_i,
  input  logic [7:0]                seed_i,
  output logic [8*(2**TX_EW)-1:0]   data_o,
  output logic [7:0]                seed_next_o
);

  localparam int NB = 2 ** TX_EW;

  logic [7:0] lfsr_s;

  // LFSR is unrolled NB steps so a full beat is produced every cycle
  always_comb begin
    data_o      = '0;
    seed_next_o = seed_i;
    lfsr_s      = seed_i;
    for (int j = 0; j < NB; j++) begin
      case (mode_i)
        MODE_INCR:  data_o[8*j +: 8] = seed_i + 8'(j);
        MODE_CONST: data_o[8*j +: 8] = seed_i;
        MODE_LFSR: begin
          data_o[8*j +: 8] = lfsr_s;
          lfsr_s           = lfsr_step(lfsr_s);
        end
        default:    data_o[8*j +: 8] = 8'h00;
      endcase
    end
    case (mode_i)
      MODE_INCR: seed_next_o = seed_i + 8'(NB);
      MODE_LFSR: seed_next_o = lfsr_s;
      default:   seed_next_o = seed_i;
    endcase
  end

endmodule

// File: rtl/tx_cmd_stream_gen.sv
// Collects a 6-byte command from the RX stream and emits LEN payload bytes on TX.
// Define TX_GEN_ABORT_EN to accept an 0xFF abort byte during SEND (terminator beat).
module tx_cmd_stream_gen
  import tx_gen_pkg::*;
#(
  parameter int TX_EW  = 2,
  parameter int PKT_EA = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      i_tready,
  input  logic                      i_tvalid,
  input  logic [7:0]                i_tdata,
  input  logic                      o_tready,
  output logic                      o_tvalid,
  output logic [8*(2**TX_EW)-1:0]   o_tdata,
  output logic [(2**TX_EW)-1:0]     o_tkeep,
  output logic                      o_tlast
);

  localparam int          NB       = 2 ** TX_EW;
  localparam int          DW       = 8 * NB;
  localparam logic [31:0] NB32     = 32'(NB);
  localparam logic [31:0] PKT_MASK = 32'((64'd1 << PKT_EA) - 64'd1);
`ifdef TX_GEN_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  state_e         state_q;
  logic [2:0]     cnt_q;
  logic [7:0]     mode_q, seed_q, pat_q;
  logic [23:0]    len_q;
  logic [31:0]    rem_q, idx_q;
  logic           fin_q, abort_q;
  logic           i_tready_q, o_tvalid_q, o_tlast_q;
  logic [DW-1:0]  o_tdata_q;
  logic [NB-1:0]  o_tkeep_q;

  logic           in_hs_s, out_hs_s, abort_now_s, mode_ok_s;
  logic [31:0]    rem_in_s, idx_in_s, nb_s, rem_d;
  logic [7:0]     pat_seed_s, pat_next_s;
  logic [DW-1:0]  pat_data_s, data_d;
  logic [NB-1:0]  keep_d;
  logic           last_d, fin_d;

  assign i_tready = i_tready_q;
  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tkeep  = o_tkeep_q;
  assign o_tlast  = o_tlast_q;

  assign in_hs_s     = i_tvalid & i_tready_q;
  assign out_hs_s    = o_tvalid_q & o_tready;
  assign mode_ok_s   = (mode_q <= 8'd2);
  assign abort_now_s = ABORT_EN & (abort_q |
                       (in_hs_s & (state_q == ST_SEND) & (i_tdata == ABORT_BYTE)));

  tx_gen_pattern #(.TX_EW(TX_EW)) u_pattern (
    .mode_i      (mode_e'(mode_q[1:0])),
    .seed_i      (pat_seed_s),
    .data_o      (pat_data_s),
    .seed_next_o (pat_next_s)
  );

  // Next-beat precompute; in CMD it prepares the first beat from the arriving LEN byte
  always_comb begin
    rem_in_s   = rem_q;
    idx_in_s   = idx_q;
    pat_seed_s = pat_q;
    if (state_q == ST_CMD) begin
      rem_in_s   = {i_tdata, len_q};
      idx_in_s   = 32'd0;
      pat_seed_s = ((mode_q[1:0] == MODE_LFSR) && (seed_q == 8'h00)) ? 8'h01 : seed_q;
    end else begin
      rem_in_s   = rem_q;
      idx_in_s   = idx_q;
      pat_seed_s = pat_q;
    end
    fin_d  = (rem_in_s <= NB32);
    nb_s   = fin_d ? rem_in_s : NB32;
    rem_d  = rem_in_s - nb_s;
    last_d = fin_d | ((idx_in_s & PKT_MASK) == PKT_MASK);
    keep_d = '0;
    data_d = '0;
    for (int j = 0; j < NB; j++) begin
      keep_d[j]        = (32'(j) < nb_s);
      data_d[8*j +: 8] = keep_d[j] ? pat_data_s[8*j +: 8] : 8'h00;
    end
  end

  // Control FSM with registered handshake and beat outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CMD;
      cnt_q      <= 3'd0;
      mode_q     <= 8'h00;
      seed_q     <= 8'h00;
      len_q      <= 24'd0;
      rem_q      <= 32'd0;
      idx_q      <= 32'd0;
      pat_q      <= 8'h00;
      fin_q      <= 1'b0;
      abort_q    <= 1'b0;
      i_tready_q <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tkeep_q  <= '0;
      o_tlast_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          i_tready_q <= 1'b1;
          abort_q    <= 1'b0;
          if (in_hs_s) begin
            case (cnt_q)
              3'd0:    mode_q         <= i_tdata;
              3'd1:    seed_q         <= i_tdata;
              3'd2:    len_q[7:0]     <= i_tdata;
              3'd3:    len_q[15:8]    <= i_tdata;
              3'd4:    len_q[23:16]   <= i_tdata;
              default: len_q          <= len_q;
            endcase
            if (cnt_q == 3'(CMD_BYTES - 1)) begin
              cnt_q <= 3'd0;
              // Reserved modes and zero-length commands are silently dropped
              if (mode_ok_s && (rem_in_s != 32'd0)) begin
                state_q    <= ST_SEND;
                i_tready_q <= ABORT_EN;
                o_tvalid_q <= 1'b1;
                o_tdata_q  <= data_d;
                o_tkeep_q  <= keep_d;
                o_tlast_q  <= last_d;
                fin_q      <= fin_d;
                rem_q      <= rem_d;
                idx_q      <= idx_in_s + 32'd1;
                pat_q      <= pat_next_s;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_SEND: begin
          if (abort_now_s) begin
            abort_q <= 1'b1;
          end
          if (out_hs_s) begin
            if (fin_q) begin
              state_q    <= ST_CMD;
              i_tready_q <= 1'b1;
              abort_q    <= 1'b0;
              o_tvalid_q <= 1'b0;
              o_tdata_q  <= '0;
              o_tkeep_q  <= '0;
              o_tlast_q  <= 1'b0;
            end else if (abort_now_s) begin
              abort_q    <= 1'b0;
              fin_q      <= 1'b1;
              o_tdata_q  <= DW'(TERM_BYTE);
              o_tkeep_q  <= NB'(1'b1);
              o_tlast_q  <= 1'b1;
            end else begin
              o_tdata_q  <= data_d;
              o_tkeep_q  <= keep_d;
              o_tlast_q  <= last_d;
              fin_q      <= fin_d;
              rem_q      <= rem_d;
              idx_q      <= idx_in_s + 32'd1;
              pat_q      <= pat_next_s;
            end
          end
        end
        default: state_q <= ST_CMD;
      endcase
    end
  end

endmodule
